// File: rtl/scomp_pkg.sv
// Shared widths and state encodings for the simple-computer memory arbiter.
package scomp_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;
    typedef enum logic {ARB = 1'b0, DBG_LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the CPU, bit 1 the debug port.
module rr_arb2
    import scomp_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       force_dbg,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (force_dbg)
            gnt[1] = req[1];
        else if (&req)
            gnt = (last_owner == OWN_DBG) ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

endmodule

// File: rtl/scomp_mem_arbiter.sv
// Shares a single-port synchronous RAM between the CPU and the debug loader,
// with a debug lock and an owner-tagged read-return pipeline.
module scomp_mem_arbiter #(
    parameter int ADDR_W = scomp_pkg::ADDR_W,
    parameter int DATA_W = scomp_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    import scomp_pkg::*;

    // Stage 0 loads at acceptance, stage STAGES lines up with ram_q.
    localparam int STAGES = 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    arb_state_t        state;
    owner_t            last_owner;
    logic [1:0]        pick;
    logic              cpu_acc, dbg_acc, acc;
    mem_req_t          win;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   own_pipe;   // 1 = debug owns the read

    rr_arb2 u_rr (
        .req       ({dbg_req, cpu_req}),
        .last_owner(last_owner),
        .force_dbg (state == DBG_LOCKED),
        .gnt       (pick)
    );

    assign cpu_gnt = reset & pick[0];
    assign dbg_gnt = reset & pick[1];
    assign cpu_acc = cpu_req & cpu_gnt;
    assign dbg_acc = dbg_req & dbg_gnt;
    assign acc     = cpu_acc | dbg_acc;

    always_comb begin
        win = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        if (dbg_acc)
            win = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ARB;
            last_owner <= OWN_DBG;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            vld_pipe   <= '0;
            own_pipe   <= '0;
        end else begin
            case (state)
                ARB:        if (dbg_acc && dbg_lock) state <= DBG_LOCKED;
                DBG_LOCKED: if (!dbg_lock) state <= ARB;
                default:    state <= ARB;
            endcase

            if (cpu_acc)
                last_owner <= OWN_CPU;
            else if (dbg_acc)
                last_owner <= OWN_DBG;

            // Address and data hold across idle cycles; only the enable drops.
            if (acc) begin
                ram_addr  <= win.addr;
                ram_wdata <= win.wdata;
                ram_we    <= win.we;
            end else begin
                ram_we    <= 1'b0;
            end

            vld_pipe <= {vld_pipe[STAGES-1:0], acc & ~win.we};
            own_pipe <= {own_pipe[STAGES-1:0], dbg_acc};
        end
    end

    assign cpu_rvalid = reset & vld_pipe[STAGES] & ~own_pipe[STAGES];
    assign dbg_rvalid = reset & vld_pipe[STAGES] &  own_pipe[STAGES];
    assign cpu_rdata  = ram_q;
    assign dbg_rdata  = ram_q;

endmodule

// File: tb/tb_scomp_mem_arbiter.sv
// Vector table plus read-data scoreboard for scomp_mem_arbiter, driving a behavioural 256x16 RAM.
module tb_scomp_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [7:0]  cpu_addr = '0, dbg_addr = '0;
    logic [15:0] cpu_wdata = '0, dbg_wdata = '0;
    logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_we;
    logic [15:0] cpu_rdata, dbg_rdata, ram_wdata, ram_q;
    logic [7:0]  ram_addr;

    scomp_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [256];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic rst;
        logic cr, cw; logic [7:0] ca; logic [15:0] cd;
        logic dr, dw; logic [7:0] da; logic [15:0] dd;
        logic lk;
        logic ecg, edg;
    } vec_t;

    typedef struct {
        int          due;
        logic        dbg;
        logic [15:0] data;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    logic [15:0] ref_mem [256];
    int          checks = 0, errors = 0, cyc = 0;
    logic        ram_chk = 1'b0, e_we = 1'b0;
    logic [7:0]  e_addr = '0;
    logic [15:0] e_wd = '0;

    function automatic vec_t v(input logic rst, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
                               input logic dr, dw, input logic [7:0] da, input logic [15:0] dd,
                               input logic lk, ecg, edg);
        vec_t r;
        r = '{rst, cr, cw, ca, cd, dr, dw, da, dd, lk, ecg, edg};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        logic ecv, edv, cacc, dacc;
        logic [15:0] ed;
        @(negedge clock);
        reset = t.rst; dbg_lock = t.lk;
        cpu_req = t.cr; cpu_we = t.cw; cpu_addr = t.ca; cpu_wdata = t.cd;
        dbg_req = t.dr; dbg_we = t.dw; dbg_addr = t.da; dbg_wdata = t.dd;
        #1;
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, t.ecg});
        chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, t.edg});

        ecv = 1'b0; edv = 1'b0; ed = '0;
        if (!t.rst) sb.delete();
        while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].dbg) edv = 1'b1; else ecv = 1'b1;
            ed = sb[0].data;
            void'(sb.pop_front());
        end
        chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, ecv});
        chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, edv});
        if (ecv) chk("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, ed});
        if (edv) chk("dbg_rdata", {16'b0, dbg_rdata}, {16'b0, ed});

        if (ram_chk) begin
            chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
            chk("ram_addr", {24'b0, ram_addr}, {24'b0, e_addr});
            if (e_we) chk("ram_wdata", {16'b0, ram_wdata}, {16'b0, e_wd});
        end

        cacc = t.rst & t.cr & t.ecg;
        dacc = t.rst & t.dr & t.edg;
        if (!t.rst) begin
            e_we = 1'b0; e_addr = '0; e_wd = '0;
        end else if (cacc) begin
            e_we = t.cw; e_addr = t.ca; e_wd = t.cd;
            if (t.cw) ref_mem[t.ca] = t.cd;
            else sb.push_back('{cyc + 2, 1'b0, ref_mem[t.ca]});
        end else if (dacc) begin
            e_we = t.dw; e_addr = t.da; e_wd = t.dd;
            if (t.dw) ref_mem[t.da] = t.dd;
            else sb.push_back('{cyc + 2, 1'b1, ref_mem[t.da]});
        end else begin
            e_we = 1'b0;
        end
        ram_chk = 1'b1;
        cyc++;
    endtask

    initial begin
        // rst  cr cw ca     cd        dr dw da     dd        lk  ecg edg
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 8'h10, 16'h1234, 1, 0, 8'h20, 16'h0,    0, 1, 0));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    0, 0, 8'h20, 16'h0,    0, 1, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    1, 1, 8'h20, 16'hBEEF, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    1, 0, 8'h20, 16'h0,    0, 0, 1));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(1, 1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0, 0, (i % 2) == 0, (i % 2) == 1));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    0, 0, 8'h00, 16'h0,    0, 0, 0));
        // lock with no accepted debug access is ignored, then takes effect
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h20, 16'h0,    1, 1, 0));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h20, 16'h0,    1, 0, 1));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h20, 16'h0,    1, 0, 1));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    0, 0, 8'h00, 16'h0,    1, 0, 0));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 1, 8'h30, 16'h5A5A, 1, 0, 1));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h30, 16'h0,    1, 0, 1));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h20, 16'h0,    0, 0, 1));
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    1, 0, 8'h20, 16'h0,    0, 1, 0));
        // CPU request withdrawn before being granted
        tbl.push_back(v(1, 1, 0, 8'h77, 16'h0,    1, 0, 8'h30, 16'h0,    0, 0, 1));
        tbl.push_back(v(1, 0, 0, 8'h77, 16'h0,    1, 0, 8'h20, 16'h0,    0, 0, 1));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    0, 0, 8'h00, 16'h0,    0, 0, 0));
        // reset drops an in-flight read but lets the pending write land
        tbl.push_back(v(1, 1, 0, 8'h10, 16'h0,    0, 0, 8'h00, 16'h0,    0, 1, 0));
        tbl.push_back(v(1, 1, 1, 8'h40, 16'hCAFE, 0, 0, 8'h00, 16'h0,    0, 1, 0));
        tbl.push_back(v(0, 1, 0, 8'h40, 16'h0,    1, 0, 8'h30, 16'h0,    0, 0, 0));
        tbl.push_back(v(1, 1, 0, 8'h40, 16'h0,    1, 0, 8'h30, 16'h0,    0, 1, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    1, 0, 8'h30, 16'h0,    0, 0, 1));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    0, 0, 8'h00, 16'h0,    0, 0, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 16'h0,    0, 0, 8'h00, 16'h0,    0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // cross-owner write/read ordering on one address
        step(v(1, 0, 0, 8'h00, 16'h0,    1, 1, 8'h55, 16'h0F0F, 0, 0, 1));
        step(v(1, 1, 0, 8'h55, 16'h0,    0, 0, 8'h00, 16'h0,    0, 1, 0));
        step(v(1, 1, 1, 8'h55, 16'hA5A5, 1, 0, 8'h55, 16'h0,    0, 0, 1));
        step(v(1, 1, 1, 8'h55, 16'hA5A5, 0, 0, 8'h00, 16'h0,    0, 1, 0));
        step(v(1, 0, 0, 8'h00, 16'h0,    1, 0, 8'h55, 16'h0,    0, 0, 1));
        for (int i = 0; i < 3; i++)
            step(v(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, 0, 0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
